// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundle between the pipeline datapath and the hazard control unit.
//   Decode / id-ex / ex-mem status flows into the control unit. Register
//   write-enables and flushes flow back out to the pipeline registers.
//
//   modport slave  : the hazard control unit (consumes status, drives controls)
//   modport master : the pipeline datapath   (drives status, consumes controls)
//
//   Status  : id_SrcReg1, id_SrcReg2, id_uses_src2, id_branch_taken,
//             ex_Data_Mem_en, ex_Data_Mem_wr, ex_WriteReg, ex_DstReg,
//             mem_access
//   Control : pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//             exmem_en, memwb_en, stall
//   Optional (HAZ_PERF_CNT_EN defined): stall_cycles, flush_count
// ---------------------------------------------------------------------------
interface hazard_ctrl_if;
  logic [3:0]  id_SrcReg1;
  logic [3:0]  id_SrcReg2;
  logic        id_uses_src2;
  logic        id_branch_taken;
  logic        ex_Data_Mem_en;
  logic        ex_Data_Mem_wr;
  logic        ex_WriteReg;
  logic [3:0]  ex_DstReg;
  logic        mem_access;

  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_flush;
  logic        exmem_en;
  logic        memwb_en;
  logic        stall;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cycles;
  logic [15:0] flush_count;
`endif

  modport slave (
    input  id_SrcReg1, id_SrcReg2, id_uses_src2, id_branch_taken,
           ex_Data_Mem_en, ex_Data_Mem_wr, ex_WriteReg, ex_DstReg, mem_access,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, stall
`ifdef HAZ_PERF_CNT_EN
  , output stall_cycles, flush_count
`endif
  );

  modport master (
    output id_SrcReg1, id_SrcReg2, id_uses_src2, id_branch_taken,
           ex_Data_Mem_en, ex_Data_Mem_wr, ex_WriteReg, ex_DstReg, mem_access,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, stall
`ifdef HAZ_PERF_CNT_EN
  , input  stall_cycles, flush_count
`endif
  );
endinterface : hazard_ctrl_if

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//   Pipeline control unit. Drives the write-enables and flushes of the
//   pc, if/id, id/ex, ex/mem and mem/wb registers.
//     - load-use hazard : hold pc and if/id, bubble id/ex for one cycle
//     - taken branch    : squash if/id
//     - data-memory access taking MEM_LAT cycles: freeze the whole pipeline
//       for MEM_LAT-1 cycles, advancing on the MEM_LAT-th
//   Priority: memory freeze > load-use > taken branch.
//
//   Ports
//     clk  : clock
//     rst  : synchronous active-high reset
//     bus  : hazard_ctrl_if.slave (status in, pipeline controls out)
//
//   Parameters
//     MEM_LAT : cycles a data-memory access occupies MEM (1..15);
//               1 disables the memory freeze entirely
//     LW_OP   : load-word opcode, kept for debug comparison only
//
//   Optional build macro HAZ_PERF_CNT_EN adds saturating 16-bit
//   performance counters bus.stall_cycles and bus.flush_count.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int         MEM_LAT = 4,
  parameter logic [3:0] LW_OP   = 4'b1000
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // The access cycle itself is the first stall cycle, so the counter covers
  // the remaining MEM_LAT-2 stall cycles before the release cycle.
  localparam bit         MEM_STALL_ON = (MEM_LAT > 1);
  localparam logic [3:0] CNT_INIT     = 4'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);

  if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_bad_mem_lat
    $error("hazard_ctrl: MEM_LAT must be within 1..15");
  end
  if (LW_OP == 4'b0000) begin : g_bad_lw_op
    $error("hazard_ctrl: LW_OP must be a non-zero opcode");
  end

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic       w_freeze;
  logic       w_load_use;

  logic       w_pc_en;
  logic       w_ifid_en;
  logic       w_ifid_flush;
  logic       w_idex_en;
  logic       w_idex_flush;
  logic       w_exmem_en;
  logic       w_memwb_en;
  logic       w_stall;

  // Load in EX whose destination is read by the instruction in decode.
  // R0 is hardwired, so a load to R0 never creates a dependency.
  assign w_load_use = bus.ex_Data_Mem_en & ~bus.ex_Data_Mem_wr &
                      bus.ex_WriteReg & (bus.ex_DstReg != 4'd0) &
                      ((bus.ex_DstReg == bus.id_SrcReg1) |
                       (bus.id_uses_src2 & (bus.ex_DstReg == bus.id_SrcReg2)));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: every signal written in a combinational block gets a default
  // first; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_freeze    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (MEM_STALL_ON && bus.mem_access) begin
          w_freeze    = 1'b1;
          w_cnt_nxt   = CNT_INIT;
          w_state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_freeze  = 1'b1;
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          // Release cycle: the access still sitting in ex/mem must not be
          // seen as a new one, so mem_access is not examined here.
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_pc_en      = 1'b1;
    w_ifid_en    = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_en    = 1'b1;
    w_idex_flush = 1'b0;
    w_exmem_en   = 1'b1;
    w_memwb_en   = 1'b1;
    w_stall      = 1'b0;
    if (rst) begin
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
    end else if (w_freeze) begin
      // Whole pipeline frozen; flushes stay low so nothing is lost.
      w_pc_en    = 1'b0;
      w_ifid_en  = 1'b0;
      w_idex_en  = 1'b0;
      w_exmem_en = 1'b0;
      w_memwb_en = 1'b0;
      w_stall    = 1'b1;
    end else if (w_load_use) begin
      // Hold fetch/decode and bubble id/ex. A concurrent taken branch is
      // not flushed; decode re-resolves it on the replayed cycle.
      w_pc_en      = 1'b0;
      w_ifid_en    = 1'b0;
      w_idex_flush = 1'b1;
      w_stall      = 1'b1;
    end else if (bus.id_branch_taken) begin
      w_ifid_flush = 1'b1;
    end
  end

  assign bus.pc_en      = w_pc_en;
  assign bus.ifid_en    = w_ifid_en;
  assign bus.ifid_flush = w_ifid_flush;
  assign bus.idex_en    = w_idex_en;
  assign bus.idex_flush = w_idex_flush;
  assign bus.exmem_en   = w_exmem_en;
  assign bus.memwb_en   = w_memwb_en;
  assign bus.stall      = w_stall;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= 16'd0;
      r_flush_count  <= 16'd0;
    end else begin
      if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
        r_stall_cycles <= r_stall_cycles + 16'd1;
      end
      if ((w_ifid_flush || w_idex_flush) && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;
`endif

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//   Self-checking bench for hazard_ctrl. Two instances share one set of
//   stimulus: dut4 (MEM_LAT=4) and dut1 (MEM_LAT=1, memory freeze disabled).
//   Controls are packed as {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//   exmem_en, memwb_en, stall}.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_ctrl;

  localparam logic [7:0] C_RESET  = 8'b0000_0000;
  localparam logic [7:0] C_FROZEN = 8'b0000_0001;
  localparam logic [7:0] C_LDUSE  = 8'b0001_1111;
  localparam logic [7:0] C_BRANCH = 8'b1111_0110;
  localparam logic [7:0] C_NORMAL = 8'b1101_0110;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   wl4   = 0;   // model: cycles left in the current access (lat 4)
  int   wl1   = 0;   // model: same for lat 1

  always #5 clk = ~clk;

  hazard_ctrl_if bus ();
  hazard_ctrl_if bus1 ();

  assign bus1.id_SrcReg1      = bus.id_SrcReg1;
  assign bus1.id_SrcReg2      = bus.id_SrcReg2;
  assign bus1.id_uses_src2    = bus.id_uses_src2;
  assign bus1.id_branch_taken = bus.id_branch_taken;
  assign bus1.ex_Data_Mem_en  = bus.ex_Data_Mem_en;
  assign bus1.ex_Data_Mem_wr  = bus.ex_Data_Mem_wr;
  assign bus1.ex_WriteReg     = bus.ex_WriteReg;
  assign bus1.ex_DstReg       = bus.ex_DstReg;
  assign bus1.mem_access      = bus.mem_access;

  hazard_ctrl #(.MEM_LAT(4), .LW_OP(4'b1000)) dut4 (.clk(clk), .rst(rst), .bus(bus.slave));
  hazard_ctrl #(.MEM_LAT(1), .LW_OP(4'b1000)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));

  // Reference model: an access occupies lat cycles; the first lat-1 freeze
  // the pipeline and the last one lets it advance without re-checking the
  // memory request. Otherwise the hazards apply in priority order.
  function automatic logic [7:0] model(input int lat, inout int wl);
    logic lu;
    bit   may_start;
    lu = bus.ex_Data_Mem_en && !bus.ex_Data_Mem_wr && bus.ex_WriteReg &&
         (bus.ex_DstReg != 4'd0) &&
         ((bus.ex_DstReg == bus.id_SrcReg1) ||
          (bus.id_uses_src2 && (bus.ex_DstReg == bus.id_SrcReg2)));
    if (rst) begin
      wl = 0;
      return C_RESET;
    end
    if (wl > 1) begin
      wl = wl - 1;
      return C_FROZEN;
    end
    may_start = (wl == 0);
    wl = 0;
    if (may_start && (lat > 1) && bus.mem_access) begin
      wl = lat - 1;
      return C_FROZEN;
    end
    if (lu) return C_LDUSE;
    if (bus.id_branch_taken) return C_BRANCH;
    return C_NORMAL;
  endfunction

  // Advance one cycle: sample both DUTs mid-cycle, step the model, then
  // move past the rising edge so the caller can change inputs.
  task automatic tick(output logic [7:0] a4, output logic [7:0] e4,
                      output logic [7:0] a1, output logic [7:0] e1);
    @(negedge clk);
    e4 = model(4, wl4);
    e1 = model(1, wl1);
    a4 = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
          bus.idex_flush, bus.exmem_en, bus.memwb_en, bus.stall};
    a1 = {bus1.pc_en, bus1.ifid_en, bus1.ifid_flush, bus1.idex_en,
          bus1.idex_flush, bus1.exmem_en, bus1.memwb_en, bus1.stall};
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_SrcReg1      = 4'd0;
    bus.id_SrcReg2      = 4'd0;
    bus.id_uses_src2    = 1'b0;
    bus.id_branch_taken = 1'b0;
    bus.ex_Data_Mem_en  = 1'b0;
    bus.ex_Data_Mem_wr  = 1'b0;
    bus.ex_WriteReg     = 1'b0;
    bus.ex_DstReg       = 4'd0;
    bus.mem_access      = 1'b0;
  endtask

  task automatic set_ex_load(input logic [3:0] dst);
    bus.ex_Data_Mem_en = 1'b1;
    bus.ex_Data_Mem_wr = 1'b0;
    bus.ex_WriteReg    = 1'b1;
    bus.ex_DstReg      = dst;
  endtask

  task automatic test_reset();
    logic [7:0] a4, e4, a1, e1;
    clear_inputs();
    rst = 1'b1;
    bus.mem_access = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(a4, e4, a1, e1);
      total++;
      if (a4 !== C_RESET) begin
        bad++;
        $display("FAIL reset_lat4[%0d]: got %b want %b", i, a4, C_RESET);
      end
      total++;
      if (a1 !== C_RESET) begin
        bad++;
        $display("FAIL reset_lat1[%0d]: got %b want %b", i, a1, C_RESET);
      end
    end
    rst = 1'b0;
    bus.mem_access = 1'b0;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_NORMAL) begin
      bad++;
      $display("FAIL after_reset: got %b want %b", a4, C_NORMAL);
    end
  endtask

  task automatic test_load_use();
    logic [7:0] a4, e4, a1, e1;
    clear_inputs();
    set_ex_load(4'd3);
    bus.id_SrcReg1   = 4'd7;
    bus.id_SrcReg2   = 4'd3;
    bus.id_uses_src2 = 1'b1;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_LDUSE) begin
      bad++;
      $display("FAIL load_use_src2: got %b want %b", a4, C_LDUSE);
    end
    // The load advances into MEM; the bubble leaves nothing in EX.
    bus.ex_Data_Mem_en = 1'b0;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_NORMAL) begin
      bad++;
      $display("FAIL load_use_one_cycle: got %b want %b", a4, C_NORMAL);
    end
    set_ex_load(4'd3);
    bus.id_uses_src2 = 1'b0;
    bus.id_SrcReg1   = 4'd5;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_NORMAL) begin
      bad++;
      $display("FAIL no_src2_no_stall: got %b want %b", a4, C_NORMAL);
    end
    set_ex_load(4'd0);
    bus.id_SrcReg1   = 4'd0;
    bus.id_SrcReg2   = 4'd0;
    bus.id_uses_src2 = 1'b1;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_NORMAL) begin
      bad++;
      $display("FAIL r0_no_stall: got %b want %b", a4, C_NORMAL);
    end
    set_ex_load(4'd9);
    bus.id_SrcReg1 = 4'd9;
    bus.ex_Data_Mem_wr = 1'b1;   // store: no dependency on its destination
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_NORMAL) begin
      bad++;
      $display("FAIL store_no_stall: got %b want %b", a4, C_NORMAL);
    end
  endtask

  task automatic test_branch();
    logic [7:0] a4, e4, a1, e1;
    clear_inputs();
    bus.id_branch_taken = 1'b1;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_BRANCH) begin
      bad++;
      $display("FAIL branch_alone: got %b want %b", a4, C_BRANCH);
    end
    set_ex_load(4'd4);
    bus.id_SrcReg1 = 4'd4;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_LDUSE) begin
      bad++;
      $display("FAIL branch_with_load_use: got %b want %b", a4, C_LDUSE);
    end
    clear_inputs();
  endtask

  task automatic test_mem_stall();
    logic [7:0] a4, e4, a1, e1;
    logic [7:0] want;
    clear_inputs();
    bus.mem_access = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(a4, e4, a1, e1);
      bus.mem_access = 1'b0;
      want = (i < 3) ? C_FROZEN : C_NORMAL;
      total++;
      if (a4 !== want) begin
        bad++;
        $display("FAIL single_access[%0d]: got %b want %b", i, a4, want);
      end
      total++;
      if (a1 !== C_NORMAL) begin
        bad++;
        $display("FAIL lat1_ignores_access[%0d]: got %b want %b", i, a1, C_NORMAL);
      end
    end
    // Held request: release cycle, then a second access on the next IDLE.
    bus.mem_access = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(a4, e4, a1, e1);
      want = ((i % 4) < 3) ? C_FROZEN : C_NORMAL;
      total++;
      if (a4 !== want) begin
        bad++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, a4, want);
      end
    end
    bus.mem_access = 1'b0;
    tick(a4, e4, a1, e1);
  endtask

  task automatic test_priority_and_abort();
    logic [7:0] a4, e4, a1, e1;
    clear_inputs();
    bus.mem_access      = 1'b1;
    bus.id_branch_taken = 1'b1;
    set_ex_load(4'd6);
    bus.id_SrcReg2   = 4'd6;
    bus.id_uses_src2 = 1'b1;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_FROZEN) begin
      bad++;
      $display("FAIL freeze_outranks_all: got %b want %b", a4, C_FROZEN);
    end
    total++;
    if (a1 !== C_LDUSE) begin
      bad++;
      $display("FAIL lat1_load_use_wins: got %b want %b", a1, C_LDUSE);
    end
    // Hazards persisting into MEM_WAIT must stay masked.
    bus.mem_access = 1'b0;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_FROZEN) begin
      bad++;
      $display("FAIL wait_masks_hazards: got %b want %b", a4, C_FROZEN);
    end
    clear_inputs();
    rst = 1'b1;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_RESET) begin
      bad++;
      $display("FAIL reset_in_wait: got %b want %b", a4, C_RESET);
    end
    rst = 1'b0;
    tick(a4, e4, a1, e1);
    total++;
    if (a4 !== C_NORMAL) begin
      bad++;
      $display("FAIL wait_aborted: got %b want %b", a4, C_NORMAL);
    end
  endtask

`ifdef HAZ_PERF_CNT_EN
  task automatic test_perf();
    logic [7:0] a4, e4, a1, e1;
    clear_inputs();
    rst = 1'b1;
    tick(a4, e4, a1, e1);
    rst = 1'b0;
    bus.mem_access = 1'b1;
    tick(a4, e4, a1, e1);
    bus.mem_access = 1'b0;
    for (int i = 0; i < 3; i++) tick(a4, e4, a1, e1);
    set_ex_load(4'd2);
    bus.id_SrcReg1 = 4'd2;
    tick(a4, e4, a1, e1);
    clear_inputs();
    tick(a4, e4, a1, e1);
    total++;
    if (bus.stall_cycles !== 16'd4) begin
      bad++;
      $display("FAIL perf_stall_cycles: got %0d want 4", bus.stall_cycles);
    end
    total++;
    if (bus.flush_count !== 16'd1) begin
      bad++;
      $display("FAIL perf_flush_count: got %0d want 1", bus.flush_count);
    end
  endtask
`endif

  task automatic test_random();
    logic [7:0] a4, e4, a1, e1;
    for (int i = 0; i < 400; i++) begin
      rst                 = ($urandom_range(0, 49) == 0);
      bus.id_SrcReg1      = 4'($urandom_range(0, 3));
      bus.id_SrcReg2      = 4'($urandom_range(0, 3));
      bus.id_uses_src2    = 1'($urandom_range(0, 1));
      bus.id_branch_taken = ($urandom_range(0, 3) == 0);
      bus.ex_Data_Mem_en  = 1'($urandom_range(0, 1));
      bus.ex_Data_Mem_wr  = ($urandom_range(0, 3) == 0);
      bus.ex_WriteReg     = ($urandom_range(0, 3) != 0);
      bus.ex_DstReg       = 4'($urandom_range(0, 3));
      bus.mem_access      = ($urandom_range(0, 5) == 0);
      tick(a4, e4, a1, e1);
      total++;
      if (a4 !== e4) begin
        bad++;
        $display("FAIL random_lat4[%0d]: got %b want %b", i, a4, e4);
      end
      total++;
      if (a1 !== e1) begin
        bad++;
        $display("FAIL random_lat1[%0d]: got %b want %b", i, a1, e1);
      end
    end
    rst = 1'b0;
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_stall();
    test_priority_and_abort();
`ifdef HAZ_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit driving the write-enable and flush inputs of the pipeline registers (pc, if/id, id/ex, ex/mem, mem/wb).
- Consumes decode-stage source registers and the id/ex register outputs to detect load-use hazards and taken branches.
- Contains a counter-based state machine that freezes the whole pipeline for multi-cycle data-memory accesses.
- Sits beside the decode stage; its idex_en/idex_flush outputs are the control end of the id/ex register interface.

Parameters:
- MEM_LAT, 4, total cycles a data-memory access occupies the MEM stage (legal range 1..15).
- LW_OP, 4'b1000, load-word opcode, used only for debug compare.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- id_SrcReg1  in  4  decode-stage source register 1
- id_SrcReg2  in  4  decode-stage source register 2
- id_uses_src2  in  1  decode instruction reads SrcReg2
- id_branch_taken  in  1  decode resolved a taken branch
- ex_Data_Mem_en  in  1  id/ex q_Data_Mem_en
- ex_Data_Mem_wr  in  1  id/ex q_Data_Mem_wr
- ex_WriteReg  in  1  id/ex q_WriteReg
- ex_DstReg  in  4  id/ex q_DstReg
- mem_access  in  1  ex/mem data-memory enable (MEM stage holds a load or store)
- pc_en  out  1  PC write enable
- ifid_en  out  1  if/id write enable
- ifid_flush  out  1  squash if/id contents
- idex_en  out  1  id/ex write enable
- idex_flush  out  1  insert bubble into id/ex control bits
- exmem_en  out  1  ex/mem write enable
- memwb_en  out  1  mem/wb write enable
- stall  out  1  any stall active (status)

Behaviour:
- Reset: while rst=1, all enables=0, both flushes=0, stall=0. Next state is IDLE and cnt=0. Reset mid-MEM_WAIT aborts the wait immediately.
- States: IDLE, MEM_WAIT. Counter cnt is 4 bits.
- load_use = ex_Data_Mem_en & ~ex_Data_Mem_wr & ex_WriteReg & (ex_DstReg != 0) & ((ex_DstReg == id_SrcReg1) | (id_uses_src2 & ex_DstReg == id_SrcReg2)).
- Default (no event): all enables=1, flushes=0, stall=0.
- IDLE, mem_access=1, MEM_LAT>1:
  - All five enables=0, flushes=0, stall=1 in the same cycle.
  - cnt<=MEM_LAT-2; go to MEM_WAIT.
- IDLE, MEM_LAT=1: mem_access is ignored; no memory stall is generated.
- MEM_WAIT, cnt!=0: all enables=0, flushes=0, stall=1; cnt decrements.
- MEM_WAIT, cnt==0: release cycle. Outputs are evaluated as in IDLE, excluding the mem_access check. Go to IDLE.
- Memory stall timing: each access stalls exactly MEM_LAT-1 cycles and the pipeline advances on the MEM_LAT-th cycle. A back-to-back access is detected on the following IDLE cycle.
- Memory stall priority: outranks load_use and branch. Both flushes are held at 0 while frozen.
- load_use (no memory stall): pc_en=0, ifid_en=0, idex_en=1, idex_flush=1, exmem_en=1, memwb_en=1, stall=1. The condition is one cycle long by construction.
- Taken branch (no memory stall, no load_use): ifid_flush=1, all enables=1.
- load_use together with id_branch_taken: load_use wins and ifid_flush=0. Decode re-resolves the branch next cycle.
- All outputs except the counter and state are combinational from inputs and state. The counter and state are the only registers.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - Adds output stall_cycles (16 bits), which increments every cycle stall=1 and saturates at 16'hFFFF.
  - Adds output flush_count (16 bits), which increments on each cycle with ifid_flush or idex_flush set and also saturates.
  - Both clear on rst.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- rst=1 for 2 cycles with mem_access=1 -> all enables 0, stall 0. After release with mem_access=0 -> all enables 1.
- ex load to R3 (en=1, wr=0, WriteReg=1, DstReg=3), id_SrcReg2=3, id_uses_src2=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1. Same with id_uses_src2=0 and SrcReg1=5 -> no stall. DstReg=0 -> no stall.
- MEM_LAT=4, mem_access=1 for one access -> stall=1 and all enables 0 for exactly 3 cycles, enables 1 on the 4th. Repeat with a back-to-back access -> a second 3-cycle stall starting the cycle after release.
- id_branch_taken=1 alone -> ifid_flush=1 for that cycle. Together with load_use -> ifid_flush=0, idex_flush=1.
- MEM_LAT=4, mem_access with load_use and branch asserted in the same cycle -> frozen, both flushes 0. rst asserted during MEM_WAIT -> next cycle IDLE with enables 1.
- HAZ_PERF_CNT_EN defined: MEM_LAT=4 access plus one load_use -> stall_cycles=4, flush_count=1.
